// File: rtl/oric_ram_bridge_if.sv
// Bus bundle between the Oric core RAM strobes, the bridge, and SDRAM controller port 1.
// master is the bridge's view; slave is the view of the core plus the SDRAM controller.
interface oric_ram_bridge_if;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic        port_req;
  logic        port_ack;
  logic [15:0] port_a;
  logic [1:0]  port_ds;
  logic        port_we;
  logic [15:0] port_d;
  logic [15:0] port_q;
  logic        busy;
  logic        overrun;

  modport master (
    input  ram_cs, ram_oe, ram_we, ram_ad, ram_d, port_ack, port_q,
    output ram_q, port_req, port_a, port_ds, port_we, port_d, busy, overrun
  );

  modport slave (
    output ram_cs, ram_oe, ram_we, ram_ad, ram_d, port_ack, port_q,
    input  ram_q, port_req, port_a, port_ds, port_we, port_d, busy, overrun
  );
endinterface

// File: rtl/oric_ram_bridge.sv
// Synchronises Oric core RAM strobes into the SDRAM clock domain and serialises the resulting
// accesses onto the SDRAM toggle-handshake port, with a one-deep pending slot.
module oric_ram_bridge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                init_n,
  oric_ram_bridge_if.master  bus
);

  typedef struct packed {
    logic        cs;
    logic        oe;
    logic        we;
    logic [15:0] ad;
    logic [7:0]  d;
  } core_smp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] ad;
    logic [7:0]  d;
  } cmd_t;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  core_smp_t sync_q [SYNC_STAGES];
  core_smp_t in_smp, s_smp, p_q;

  state_e      state_q, state_d;
  cmd_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  ram_q_q, ram_q_d;
  logic        port_req_q, port_req_d;
  logic [15:0] port_a_q, port_a_d;
  logic [1:0]  port_ds_q, port_ds_d;
  logic        port_we_q, port_we_d;
  logic [15:0] port_d_q, port_d_d;

  logic stable, wr_evt, rd_evt, evt, issue;
  cmd_t evt_cmd, issue_cmd;

  assign in_smp = {bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_ad, bus.ram_d};
  assign s_smp  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= in_smp;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      p_q <= s_smp;
    end
  end

  // Only trust the sample once the address has settled across the last two stages.
  assign stable  = (s_smp.ad == sync_q[SYNC_STAGES-2].ad);
  assign wr_evt  = stable & s_smp.cs & s_smp.we & ~(p_q.cs & p_q.we);
  assign rd_evt  = stable & s_smp.cs & s_smp.oe & (~(p_q.cs & p_q.oe) | (s_smp.ad != p_q.ad));
  assign evt     = wr_evt | rd_evt;
  assign evt_cmd = '{we: wr_evt, ad: s_smp.ad, d: s_smp.d};

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = overrun_q;
    ram_q_d    = ram_q_q;
    port_req_d = port_req_q;
    port_a_d   = port_a_q;
    port_ds_d  = port_ds_q;
    port_we_d  = port_we_q;
    port_d_d   = port_d_q;
    issue      = 1'b0;
    issue_cmd  = pend_q;

    case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          issue      = 1'b1;
          issue_cmd  = pend_q;
          pend_vld_d = 1'b0;
          // The slot frees this cycle, so a coincident event refills it without overrun.
          if (evt) begin
            pend_d     = evt_cmd;
            pend_vld_d = 1'b1;
          end
        end else if (evt) begin
          issue     = 1'b1;
          issue_cmd = evt_cmd;
        end
      end
      StWait: begin
        if (bus.port_ack == port_req_q) begin
          if (!port_we_q) ram_q_d = port_a_q[0] ? bus.port_q[15:8] : bus.port_q[7:0];
          state_d = StIdle;
        end
        if (evt) begin
          if (pend_vld_q) overrun_d = 1'b1;
          pend_d     = evt_cmd;
          pend_vld_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      state_d    = StWait;
      port_req_d = ~port_req_q;
      port_a_d   = issue_cmd.ad;
      port_we_d  = issue_cmd.we;
      port_d_d   = {issue_cmd.d, issue_cmd.d};
      port_ds_d  = issue_cmd.we ? (issue_cmd.ad[0] ? 2'b10 : 2'b01) : 2'b11;
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
      ram_q_q    <= 8'h00;
      port_req_q <= 1'b0;
      port_a_q   <= 16'h0000;
      port_ds_q  <= 2'b11;
      port_we_q  <= 1'b0;
      port_d_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      overrun_q  <= overrun_d;
      ram_q_q    <= ram_q_d;
      port_req_q <= port_req_d;
      port_a_q   <= port_a_d;
      port_ds_q  <= port_ds_d;
      port_we_q  <= port_we_d;
      port_d_q   <= port_d_d;
    end
  end

  assign bus.ram_q    = ram_q_q;
  assign bus.port_req = port_req_q;
  assign bus.port_a   = port_a_q;
  assign bus.port_ds  = port_ds_q;
  assign bus.port_we  = port_we_q;
  assign bus.port_d   = port_d_q;
  assign bus.busy     = (state_q == StWait) | pend_vld_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: doc/oric_ram_bridge.md
# oric_ram_bridge

Bridges the Oric core's asynchronous-style RAM strobes (ram_cs/ram_oe/ram_we, ram_ad, ram_d, produced in the 24 MHz core domain) onto the SDRAM controller's toggle-handshake port 1, running in the 72 MHz SDRAM domain. It sits directly upstream of the sdram block. It synchronises the strobes, detects access events, serialises them with a one-deep pending slot, and returns byte-selected read data to the core.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for ram_cs/ram_oe/ram_we/ram_ad/ram_d (legal 2..3).

Ports:
- clk, input, 1, SDRAM-domain clock (72 MHz); all logic on rising edge.
- init_n, input, 1, asynchronous active-low reset.
- ram_cs, input, 1, core RAM select (24 MHz domain).
- ram_oe, input, 1, core read strobe.
- ram_we, input, 1, core write strobe.
- ram_ad, input, 16, core byte address.
- ram_d, input, 8, core write data.
- ram_q, output, 8, read data to core, held until next read completes.
- port_req, output, 1, request toggle to sdram.
- port_ack, input, 1, ack toggle from sdram; access done when port_ack == port_req.
- port_a, output, 16, latched byte address.
- port_ds, output, 2, byte enables: read 2'b11; write 2'b01 if addr[0]=0, 2'b10 if addr[0]=1.
- port_we, output, 1, write request.
- port_d, output, 16, {wdata, wdata}.
- port_q, input, 16, sdram read word, valid when ack matches.
- busy, output, 1, high in WAIT or while pending slot full.
- overrun, output, 1, sticky: a pending event was overwritten.

## Operation
- All core inputs pass through SYNC_STAGES flops; last synchronised sample S, previous sample P (one more register).
- Stable qualifier: event evaluation only when the final two synchroniser stages agree on ram_ad (suppresses mid-transition address).
- Events (evaluated on S vs P):
  - write: S.cs&S.we & ~(P.cs&P.we).
  - read: S.cs&S.oe & ~(P.cs&P.oe), or S.cs&S.oe & (S.ad != P.ad).
  - both in same cycle: single write command (write priority).
- Command = {we, ad, d} captured from S.
- FSM, two states:
  - IDLE: if pending valid, issue pending (pending cleared); else if event, issue event command. Issue = load port_a/port_we/port_ds/port_d, toggle port_req, go WAIT. port_ack ignored in IDLE.
  - WAIT: when port_ack == port_req: if read, ram_q <= port_a[0] ? port_q[15:8] : port_q[7:0]; go IDLE. Writes leave ram_q unchanged.
- Pending slot: event occurring in WAIT (including the completion cycle) is stored; if slot already valid, overwritten and overrun <= 1.
- port_* hold their values from issue until next issue.
- Reset mid-access: FSM to IDLE, pending dropped, all outputs to reset values; sdram shares init_n so its ack realigns to 0.

## Timing
- Reset values: ram_q=8'h00, port_req=0, port_a=16'h0000, port_ds=2'b11, port_we=0, port_d=16'h0000, busy=0, overrun=0.
- Event latency: core strobe change visible in S after SYNC_STAGES clk edges; issue (port_req toggle) on the edge where S shows the event, if IDLE and no pending.
- Read data: ram_q updates on the edge where port_ack == port_req is sampled in WAIT.
- Back-to-back: after completion, one IDLE cycle, then pending issues on the next edge (min 2 clk between successive toggles).
- Address/data/ds/we stable on outputs at least from the toggle edge until ack match.
- busy asserted from issue edge; deasserts the edge FSM enters IDLE with no pending.

## Test plan
- Reset: hold init_n=0, drive strobes randomly -> all outputs at reset values, no port_req toggle.
- Read: ad=16'h1235, cs=oe=1; sdram model acks after 5 clk with port_q=16'hAB12 -> one toggle, port_ds=2'b11, port_we=0, ram_q=8'hAB, busy low after completion.
- Write: ad=16'h0400, d=8'h5A, cs=we=1 -> one toggle, port_we=1, port_ds=2'b01, port_d=16'h5A5A; ram_q unchanged.
- Address sweep with cs=oe held: ad 16'h2000 -> 16'h2001 -> one toggle per address, 2 total; ram_q follows each word byte.
- Overrun: ack delayed 40 clk, three read events during WAIT -> first issued, third replaces second in pending, overrun=1, total 2 toggles.
- Simultaneous oe/we rise at ad=16'h0001 -> one write command, port_ds=2'b10; init_n pulsed mid-WAIT -> outputs return to reset values, pending lost.
